// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with frame validation and a receive FIFO.
//
// The raw RX line is synchronised, frames are sampled mid-bit by a baud
// counter, checked (false start, optional parity, stop bits) and the data
// plus per-word error flags are queued in a small circular FIFO that the
// bus side drains with a valid/ready handshake.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   uart_rx             asynchronous serial line, idle high
//   rd_valid/rd_ready   FIFO head handshake (pop on valid && ready)
//   rd_data             head entry data (DATA_BITS wide)
//   rd_parity_err       head entry parity mismatch
//   rd_frame_err        head entry saw a 0 in a stop-bit sample
//   overrun             sticky: a completed frame was dropped (FIFO full)
//   overrun_clr         single-cycle clear of overrun
//   fifo_count          entries currently held
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rx,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_parity_err,
  output logic                          rd_frame_err,
  output logic                          overrun,
  input  logic                          overrun_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);

  if (CPB < 8) begin : g_bad_cpb
    $error("uart_rx_fifo: CLK_FREQ/BAUD must be >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_db
    $error("uart_rx_fifo: DATA_BITS must be 5..8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 parity_err;
    logic                 frame_err;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchroniser + edge detect
  // ---------------------------------------------------------------------
  logic rx_m, rx_s, rx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= uart_rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  logic fall;
  assign fall = rx_d & ~rx_s;

  // ---------------------------------------------------------------------
  // Receive FSM (state register + next-state logic)
  // ---------------------------------------------------------------------
  state_t               state, state_n;
  logic [CW-1:0]        baud_cnt, baud_cnt_n;
  logic [3:0]           bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 pe_r, pe_n;
  logic                 fe_r, fe_n;
  logic                 tick;
  logic                 push;
  entry_t               push_ent;

  assign tick = (state != S_IDLE) && (baud_cnt == CW'(0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      pe_r     <= 1'b0;
      fe_r     <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      pe_r     <= pe_n;
      fe_r     <= fe_n;
    end
  end

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    pe_n       = pe_r;
    fe_n       = fe_r;
    push       = 1'b0;

    if (state != S_IDLE)
      baud_cnt_n = tick ? CW'(CPB - 1) : baud_cnt - CW'(1);

    case (state)
      S_IDLE: begin
        // Half-bit load puts every later tick in the middle of a bit.
        if (fall) begin
          baud_cnt_n = CW'(CPB / 2 - 1);
          pe_n       = 1'b0;
          fe_n       = 1'b0;
          state_n    = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (rx_s) begin
            state_n = S_IDLE;       // line back high mid start bit: glitch
          end else begin
            bit_cnt_n = '0;
            state_n   = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shreg_n   = {rx_s, shreg[DATA_BITS-1:1]};
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'(DATA_BITS - 1)) begin
            bit_cnt_n = '0;
            state_n   = (PARITY != 0) ? S_PAR : S_STOP;
          end
        end
      end
      S_PAR: begin
        if (tick) begin
          pe_n    = (PARITY == 1) ? (^shreg ^ rx_s) : ~(^shreg ^ rx_s);
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          fe_n      = fe_r | ~rx_s;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'(STOP_BITS - 1)) begin
            bit_cnt_n = '0;
            push      = 1'b1;
            state_n   = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign push_ent.data       = shreg;
  assign push_ent.parity_err = pe_r;
  assign push_ent.frame_err  = fe_n;

  // ---------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------
  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, do_push;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign rd_valid = (count != '0);
  assign pop     = rd_valid & rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_ent;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      overrun <= 1'b0;
    else if (push && !do_push)
      overrun <= 1'b1;
    else if (overrun_clr)
      overrun <= 1'b0;
  end

  assign rd_data       = mem[rd_ptr].data;
  assign rd_parity_err = mem[rd_ptr].parity_err;
  assign rd_frame_err  = mem[rd_ptr].frame_err;
  assign fifo_count    = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed + randomized bench for uart_rx_fifo.
// Two instances share the clock: u_n (8N1) and u_e (8E1), each with its own
// line. A queue per instance models the FIFO contents and the overrun flag.
module tb_uart_rx_fifo;

  localparam int CF    = 1600000;
  localparam int BR    = 100000;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_n, rx_e, rdy_n, rdy_e, clr_n, clr_e;
  logic       v_n, v_e, pe_n, pe_e, fe_n, fe_e, ov_n, ov_e;
  logic [7:0] d_n, d_e;
  logic [2:0] c_n, c_e;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_n (
    .clk(clk), .rst(rst), .uart_rx(rx_n), .rd_valid(v_n), .rd_ready(rdy_n),
    .rd_data(d_n), .rd_parity_err(pe_n), .rd_frame_err(fe_n),
    .overrun(ov_n), .overrun_clr(clr_n), .fifo_count(c_n));

  uart_rx_fifo #(.CLK_FREQ(CF), .BAUD(BR), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_e (
    .clk(clk), .rst(rst), .uart_rx(rx_e), .rd_valid(v_e), .rd_ready(rdy_e),
    .rd_data(d_e), .rd_parity_err(pe_e), .rd_frame_err(fe_e),
    .overrun(ov_e), .overrun_clr(clr_e), .fifo_count(c_e));

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } ent_t;

  ent_t q_n[$];
  ent_t q_e[$];
  bit   mov_n, mov_e;
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic b);
    if (w == 0) rx_n = b; else rx_e = b;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: a completed frame lands in the queue unless it is full and
  // nothing is popped in that cycle.
  task automatic model_push(input int w, input logic [7:0] d, input logic pbit,
                            input logic stopv, input bit popped);
    ent_t e;
    e.d  = d;
    e.pe = (w == 1) ? ^{d, pbit} : 1'b0;
    e.fe = ~stopv;
    if (w == 0) begin
      if (popped && q_n.size() > 0) void'(q_n.pop_front());
      if (q_n.size() < DEPTH) q_n.push_back(e); else mov_n = 1'b1;
    end else begin
      if (popped && q_e.size() > 0) void'(q_e.pop_front());
      if (q_e.size() < DEPTH) q_e.push_back(e); else mov_e = 1'b1;
    end
  endtask

  // mode 0: plain, 1: check rd_valid latency, 2: pop in the push cycle.
  // cut > 0 stops driving the frame after that many cycles.
  task automatic send(input int w, input logic [7:0] d, input logic pbit,
                      input logic stopv, input int mode, input int cut);
    logic [10:0] bits;
    int nb, pc, lim;
    nb = (w == 1) ? 11 : 10;
    pc = (w == 1) ? 170 : 154;  // cycles from start-bit drive to push edge
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    if (w == 1) begin bits[9] = pbit; bits[10] = stopv; end
    else bits[9] = stopv;
    lim = (cut > 0) ? cut : nb * 16;
    for (int c = 0; c < lim; c++) begin
      drive(w, bits[c/16]);
      @(negedge clk);
      if (mode == 1 && c + 1 == pc)     chk("latency_pre", (w == 0) ? v_n : v_e, 1'b0);
      if (mode == 1 && c + 1 == pc + 1) chk("latency_post", (w == 0) ? v_n : v_e, 1'b1);
      if (mode == 2 && c + 1 == pc)     begin if (w == 0) rdy_n = 1'b1; else rdy_e = 1'b1; end
      if (mode == 2 && c + 1 == pc + 1) begin rdy_n = 1'b0; rdy_e = 1'b0; end
    end
    drive(w, 1'b1);
    if (cut == 0) model_push(w, d, pbit, stopv, mode == 2);
  endtask

  task automatic check_state(input int w, input string tag);
    logic v, pe, fe, ov;
    logic [7:0] d;
    logic [2:0] cnt;
    ent_t h;
    int sz;
    bit mov;
    if (w == 0) begin
      v = v_n; d = d_n; pe = pe_n; fe = fe_n; ov = ov_n; cnt = c_n;
      sz = q_n.size(); mov = mov_n; if (sz > 0) h = q_n[0];
    end else begin
      v = v_e; d = d_e; pe = pe_e; fe = fe_e; ov = ov_e; cnt = c_e;
      sz = q_e.size(); mov = mov_e; if (sz > 0) h = q_e[0];
    end
    chk({tag, " count"}, cnt, sz);
    chk({tag, " valid"}, v, sz != 0);
    chk({tag, " overrun"}, ov, mov);
    if (sz > 0) begin
      chk({tag, " data"}, d, h.d);
      chk({tag, " perr"}, pe, h.pe);
      chk({tag, " ferr"}, fe, h.fe);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " n_out"}, {v_n, d_n, pe_n, fe_n, ov_n, c_n}, '0);
    chk({tag, " e_out"}, {v_e, d_e, pe_e, fe_e, ov_e, c_e}, '0);
  endtask

  task automatic pop(input int w);
    if (w == 0) rdy_n = 1'b1; else rdy_e = 1'b1;
    @(negedge clk);
    rdy_n = 1'b0; rdy_e = 1'b0;
    if (w == 0) begin if (q_n.size() > 0) void'(q_n.pop_front()); end
    else begin if (q_e.size() > 0) void'(q_e.pop_front()); end
  endtask

  task automatic clr(input int w);
    if (w == 0) clr_n = 1'b1; else clr_e = 1'b1;
    @(negedge clk);
    clr_n = 1'b0; clr_e = 1'b0;
    if (w == 0) mov_n = 1'b0; else mov_e = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    q_n.delete(); q_e.delete();
    mov_n = 1'b0; mov_e = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rx_n = 1'b1; rx_e = 1'b1;
    rdy_n = 1'b0; rdy_e = 1'b0; clr_n = 1'b0; clr_e = 1'b0;
    mov_n = 1'b0; mov_e = 1'b0;
    @(negedge clk);
    do_reset();
    check_reset("reset");

    // Basic 8N1 frame with push latency check
    send(0, 8'hA5, 1'b0, 1'b1, 1, 0);
    idle(4);
    check_state(0, "a5");
    pop(0);
    check_state(0, "a5_pop");

    // Glitch shorter than half a bit is rejected
    rx_n = 1'b0; idle(4); rx_n = 1'b1; idle(40);
    check_state(0, "glitch");
    send(0, 8'h3C, 1'b0, 1'b1, 0, 0);
    idle(4);
    check_state(0, "3c");
    pop(0);

    // Even parity
    send(1, 8'h03, 1'b1, 1'b1, 0, 0);
    idle(4);
    check_state(1, "par03");
    pop(1);
    send(1, 8'h07, 1'b1, 1'b1, 0, 0);
    idle(4);
    check_state(1, "par07");
    pop(1);

    // Framing error, then clean frame after one idle bit
    send(0, 8'h55, 1'b0, 1'b0, 0, 0);
    idle(16);
    check_state(0, "ferr55");
    send(0, 8'h12, 1'b0, 1'b1, 0, 0);
    idle(4);
    pop(0);
    check_state(0, "after_ferr");
    pop(0);

    // Overflow: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) begin
      send(0, 8'(i), 1'b0, 1'b1, 0, 0);
      idle(4);
      check_state(0, "fill");
    end
    for (int i = 0; i < 4; i++) begin
      check_state(0, "drain");
      pop(0);
    end
    check_state(0, "drained");
    clr(0);
    check_state(0, "ov_clr");

    // Full FIFO with a pop in the same cycle as the push
    for (int i = 1; i <= 4; i++) send(0, 8'(i), 1'b0, 1'b1, 0, 0);
    send(0, 8'h05, 1'b0, 1'b1, 2, 0);
    idle(4);
    check_state(0, "full_pop");
    while (q_n.size() > 0) pop(0);
    check_state(0, "full_pop_drained");

    // Reset in the middle of a data bit
    send(0, 8'h44, 1'b0, 1'b1, 0, 0);
    idle(4);
    send(0, 8'hF0, 1'b0, 1'b1, 0, 16 * 4 + 5);
    rx_n = 1'b1;
    do_reset();
    check_reset("mid_rst");
    idle(20);
    send(0, 8'h81, 1'b0, 1'b1, 0, 0);
    idle(4);
    check_state(0, "81");
    pop(0);

    // Randomized frames against the queue model
    for (int r = 0; r < 8; r++) begin
      int w, nf;
      w  = $urandom_range(0, 1);
      nf = $urandom_range(1, 6);
      for (int f = 0; f < nf; f++) begin
        logic [7:0] d;
        logic pb, sv;
        d  = 8'($urandom);
        pb = 1'($urandom);
        sv = ($urandom_range(0, 3) != 0);
        send(w, d, pb, sv, 0, 0);
        idle(16);
        check_state(w, "rnd_push");
      end
      if ($urandom_range(0, 1) == 1) begin
        clr(w);
        check_state(w, "rnd_clr");
      end
      while ((w == 0 ? q_n.size() : q_e.size()) > 0) begin
        pop(w);
        check_state(w, "rnd_pop");
      end
      clr(w);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
